fetch_sequencer: RTL and testbench

Instruction-fetch sequencer directly downstream of the word opcode buffer. Generates the fetch address stream, drives the buffer's load handshake, collects returned opcodes into a small prefetch queue tagged with their addresses, and presents them to the decode stage with a valid/ready handshake. Branch redirects flush the queue and discard any fetch still in flight.

---
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: opcode-buffer load handshake, branch redirect and decode output.
// The sequencer holds the master modport; the buffer/decode environment holds the slave modport.
interface fetch_sequencer_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int WORD_WIDTH    = 32
);
    // Buffer side: bufStart is a one-cycle request, and bufBusy rises on the following edge.
    // The word is valid on bufOpcode once bufBusy has fallen.
    // Decode side: the head entry transfers on every rising edge where opValid && opReady.
    // opValid never depends on opReady.
    logic [ADDRESS_WIDTH-1:0] bufIp;
    logic                     bufStart;
    logic                     bufBusy;
    logic [WORD_WIDTH-1:0]    bufOpcode;
    logic                     redirect;
    logic [ADDRESS_WIDTH-1:0] redirectTarget;
    logic                     opValid;
    logic [WORD_WIDTH-1:0]    opcode;
    logic [ADDRESS_WIDTH-1:0] opAddress;
    logic                     opReady;
    logic [1:0]               dbgState;

    modport master (
        output bufIp, bufStart, opValid, opcode, opAddress, dbgState,
        input  bufBusy, bufOpcode, redirect, redirectTarget, opReady
    );

    modport slave (
        input  bufIp, bufStart, opValid, opcode, opAddress, dbgState,
        output bufBusy, bufOpcode, redirect, redirectTarget, opReady
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives single-outstanding buffer loads, tags returned words
// with their address in a small prefetch queue, and flushes on branch redirect.
module fetch_sequencer #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       WORD_WIDTH    = 32,
    parameter int                       DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0
) (
    input logic              clk,
    input logic              reset,
    fetch_sequencer_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(WORD_WIDTH / 8);
    localparam logic [CNT_W-1:0]         FULL    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2,
        DATA  = 2'd3
    } state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     discard;
    logic                     start_q;
    logic [ADDRESS_WIDTH-1:0] ip_q;

    logic [WORD_WIDTH-1:0]    q_op   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] q_addr [DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         count;

    logic                     capture;
    logic                     push;
    logic                     pop;
    logic [CNT_W-1:0]         count_next;
    logic [ADDRESS_WIDTH-1:0] pc_after;
    logic [ADDRESS_WIDTH-1:0] pc_next_fetch;

    always_comb begin
        capture    = (state == DATA) && !bus.bufBusy;
        push       = capture && !discard && !bus.redirect;
        pop        = bus.opReady && (count != '0) && !bus.redirect;
        count_next = count;
        if (bus.redirect) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
        // A discarded word was fetched from a stale pc, so pc already holds the new target.
        pc_after      = discard ? pc : pc + PC_STEP;
        pc_next_fetch = bus.redirect ? bus.redirectTarget : pc_after;
    end

    // Queue storage carries no reset; entries are only observable while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr]   <= bus.bufOpcode;
            q_addr[wr_ptr] <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_VECTOR;
            discard <= 1'b0;
            start_q <= 1'b0;
            ip_q    <= '0;
        end else begin
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.redirect) begin
                        pc      <= bus.redirectTarget;
                        state   <= ISSUE;
                        start_q <= 1'b1;
                        ip_q    <= bus.redirectTarget;
                    end else if (count < FULL) begin
                        state   <= ISSUE;
                        start_q <= 1'b1;
                        ip_q    <= pc;
                    end
                end
                ISSUE: begin
                    // The request has already left, so a redirect here must drop its reply.
                    state <= ACK;
                    if (bus.redirect) begin
                        pc      <= bus.redirectTarget;
                        discard <= 1'b1;
                    end
                end
                ACK: begin
                    if (bus.redirect) begin
                        pc      <= bus.redirectTarget;
                        discard <= 1'b1;
                    end
                    if (bus.bufBusy) state <= DATA;
                end
                DATA: begin
                    if (capture) begin
                        pc      <= pc_next_fetch;
                        discard <= 1'b0;
                        if (count_next < FULL) begin
                            state   <= ISSUE;
                            start_q <= 1'b1;
                            ip_q    <= pc_next_fetch;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bus.redirect) begin
                        pc      <= bus.redirectTarget;
                        discard <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bufStart  = start_q;
    assign bus.bufIp     = ip_q;
    assign bus.opValid   = (count != '0);
    assign bus.opcode    = (count != '0) ? q_op[rd_ptr] : '0;
    assign bus.opAddress = (count != '0) ? q_addr[rd_ptr] : '0;
    assign bus.dbgState  = state;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an opcode-buffer model and an address/opcode
// scoreboard fed by the directed steps and drained on every decode transfer.
module tb_fetch_sequencer;
    localparam int AW = 32;
    localparam int WW = 32;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   issue_cnt;
    int   ram_wait;
    int   busy_cnt;
    logic [AW-1:0] ip_lat;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] ea;
    logic [AW-1:0] exp_q[$];

    fetch_sequencer_if #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

    fetch_sequencer #(
        .ADDRESS_WIDTH(AW),
        .WORD_WIDTH   (WW),
        .DEPTH        (4),
        .RESET_VECTOR (32'h100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [WW-1:0] ram_data(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0f0f;
    endfunction

    // opcode buffer model: busy for 1+ram_wait cycles after a sampled start
    always @(posedge clk) begin
        if (reset) begin
            bus.bufBusy   <= 1'b0;
            bus.bufOpcode <= '0;
            busy_cnt      <= 0;
        end else if (bus.bufStart && !bus.bufBusy) begin
            bus.bufBusy <= 1'b1;
            ip_lat      <= bus.bufIp;
            busy_cnt    <= ram_wait;
        end else if (bus.bufBusy) begin
            if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
            end else begin
                bus.bufBusy   <= 1'b0;
                bus.bufOpcode <= ram_data(ip_lat);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // scoreboard: every decode transfer pops one expected address
    always @(negedge clk) begin
        if (!reset && bus.bufStart) issue_cnt++;
        if (!reset && bus.opValid && bus.opReady && !bus.redirect) begin
            if (exp_q.size() > 0) ea = exp_q.pop_front();
            else ea = last_addr + 32'd4;
            last_addr = ea;
            chk("sb_addr", 64'(bus.opAddress), 64'(ea));
            chk("sb_opcode", 64'(bus.opcode), 64'(ram_data(ea)));
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        run(3);
        exp_q.delete();
        issue_cnt = 0;
    endtask

    task automatic pulse_redirect(input logic [AW-1:0] target);
        bus.redirect       = 1'b1;
        bus.redirectTarget = target;
        step();
        bus.redirect = 1'b0;
    endtask

    initial begin
        logic [6:0] valid_pat;
        logic [6:0] start_pat;
        bit         seen;
        total = 0;
        bad = 0;
        issue_cnt = 0;
        ram_wait = 0;
        last_addr = '0;
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.redirectTarget = '0;
        bus.opReady = 1'b1;

        // reset values and first-word latency
        run(3);
        @(negedge clk);
        chk("rst_bufStart", 64'(bus.bufStart), 64'd0);
        chk("rst_bufIp", 64'(bus.bufIp), 64'd0);
        chk("rst_opValid", 64'(bus.opValid), 64'd0);
        chk("rst_opcode", 64'(bus.opcode), 64'd0);
        chk("rst_opAddress", 64'(bus.opAddress), 64'd0);
        chk("rst_state", 64'(bus.dbgState), 64'd0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("pre_e0_state", 64'(bus.dbgState), 64'd0);
        valid_pat = 7'b1001000;
        start_pat = 7'b1001001;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("lat_opValid", 64'(bus.opValid), 64'(valid_pat[k]));
            chk("lat_bufStart", 64'(bus.bufStart), 64'(start_pat[k]));
            if (start_pat[k]) chk("lat_bufIp", 64'(bus.bufIp), 64'(32'h100 + 32'(k / 3) * 32'd4));
        end
        run(20);
        chk("seq_drained", 64'(exp_q.size()), 64'd0);

        // full queue with decode stalled, then release
        bus.opReady = 1'b0;
        hold_reset();
        reset = 1'b0;
        run(40);
        chk("full_issues", 64'(issue_cnt), 64'd4);
        chk("full_state", 64'(bus.dbgState), 64'd0);
        chk("full_opValid", 64'(bus.opValid), 64'd1);
        chk("full_head", 64'(bus.opAddress), 64'h100);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'h100 + 32'(i) * 32'd4);
        bus.opReady = 1'b1;
        step();
        @(negedge clk);
        chk("full_pop_nostart", 64'(bus.bufStart), 64'd0);
        @(negedge clk);
        chk("full_5th_start", 64'(bus.bufStart), 64'd1);
        chk("full_5th_ip", 64'(bus.bufIp), 64'h110);
        run(40);
        chk("full_drained", 64'(exp_q.size()), 64'd0);

        // redirect while DATA waits on a slow buffer
        hold_reset();
        ram_wait = 2;
        exp_q.push_back(32'h2000);
        exp_q.push_back(32'h2004);
        reset = 1'b0;
        run(3);
        chk("slow_in_data", 64'(bus.dbgState), 64'd3);
        pulse_redirect(32'h2000);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.bufStart) begin
                seen = 1;
                chk("slow_next_ip", 64'(bus.bufIp), 64'h2000);
            end else begin
                chk("slow_no_stale", 64'(bus.opValid), 64'd0);
            end
        end
        chk("slow_start_seen", 64'(seen), 64'd1);
        run(40);
        chk("slow_drained", 64'(exp_q.size()), 64'd0);
        ram_wait = 0;

        // redirect coinciding with a capture and a pop
        bus.opReady = 1'b0;
        hold_reset();
        reset = 1'b0;
        run(6);
        chk("coin_in_data", 64'(bus.dbgState), 64'd3);
        chk("coin_has_head", 64'(bus.opValid), 64'd1);
        exp_q.delete();
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3004);
        bus.opReady = 1'b1;
        pulse_redirect(32'h3000);
        @(negedge clk);
        chk("coin_empty", 64'(bus.opValid), 64'd0);
        chk("coin_start", 64'(bus.bufStart), 64'd1);
        chk("coin_ip", 64'(bus.bufIp), 64'h3000);
        run(20);
        chk("coin_drained", 64'(exp_q.size()), 64'd0);

        // pc wrap through the top of the address space
        exp_q.delete();
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        pulse_redirect(32'hFFFF_FFFC);
        run(40);
        chk("wrap_drained", 64'(exp_q.size()), 64'd0);

        // reset in the middle of a DATA wait
        hold_reset();
        ram_wait = 3;
        reset = 1'b0;
        run(4);
        chk("mid_in_data", 64'(bus.dbgState), 64'd3);
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("mid_bufStart", 64'(bus.bufStart), 64'd0);
        chk("mid_bufIp", 64'(bus.bufIp), 64'd0);
        chk("mid_opValid", 64'(bus.opValid), 64'd0);
        chk("mid_opAddress", 64'(bus.opAddress), 64'd0);
        chk("mid_state", 64'(bus.dbgState), 64'd0);
        ram_wait = 0;
        hold_reset();
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("mid_restart_ip", 64'(bus.bufIp), 64'h100);
        run(25);
        chk("mid_drained", 64'(exp_q.size()), 64'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
